tff_updown_counter: RTL and testbench
=====================================

// Module: tff_updown_counter
// PURPOSE
//   Synchronous N-bit up/down counter built as a bank of T flip-flop stages.
//   Each bit updates as q[i] <= q[i] ^ t_vec[i]. A toggle-generation stage computes
//   t_vec from the count, direction, modulo limit and load request.
//   Sits directly downstream of the single-bit tff cell: it generates the T inputs and
//   consumes the q outputs. It replaces the hand-wired 2-bit counter.
//   Cascadable via cin/cout for wider chains.
// PARAMETERS
//   W    2        counter width in bits (>=1)
//   MAX  2**W-1   terminal value; count range is 0..MAX (MAX <= 2**W-1)
// PORTS
//   clk       in   1  clock; all state changes on rising edge
//   clear     in   1  reset, synchronous, active-low (0 = reset on next rising clk)
//   en        in   1  count enable
//   cin       in   1  cascade carry-in; counting requires en & cin (tie 1 if unused)
//   up        in   1  direction: 1 = increment, 0 = decrement
//   load      in   1  synchronous parallel load request
//   load_val  in   W  value to load
//   q         out  W  current count
//   qb        out  W  ~q, bitwise, always
//   t_vec     out  W  combinational toggle vector applied this cycle (q ^ q_next)
//   cout      out  1  combinational: en & cin & (up ? q==MAX : q==0)
//   tc        out  1  registered terminal-count pulse
// BEHAVIOUR
//   Reset: when clear==0 at a rising edge: q=0, qb={W{1}}, tc=0.
//     Reset overrides load and en. A mid-count reset takes effect on that edge.
//   Priority per edge: reset > load > count > hold.
//   load=1: q_next = (load_val > MAX) ? MAX : load_val. tc_next=0. en, cin, up ignored.
//   Count (en & cin, no load):
//     up=1:   q_next = (q==MAX) ? 0 : q+1
//     up=0:   q_next = (q==0) ? MAX : q-1
//     tc_next = 1 exactly when that edge wraps (MAX->0 up, 0->MAX down); else 0.
//   Hold (no load, !(en&cin)): q_next = q, t_vec = 0, tc_next = 0.
//   t_vec = q ^ q_next at all times. It is 0 while holding.
//     State is held only by toggling: q <= q ^ t_vec. Reset is the only direct write.
//   tc: high for exactly one cycle following a wrapping edge.
//     Back-to-back wraps are possible when MAX==0; tc then stays high while counting.
//   cout is combinational and becomes valid in the cycle before the wrap.
//     Feed it to the next stage's cin, which then advances on the same edge.
//   Out-of-range q: q > MAX is unreachable by reset, load clamp or count.
//     If forced, up-count wraps to 0 and down-count decrements normally.
//   Direction change takes effect on the next counting edge. No extra latency.
//   Latency: load/count/reset visible on q one edge after being sampled.
// TESTING
//   1. W=2, MAX=3: clear=0 for 2 clk, then clear=1, en=cin=up=1 for 5 edges
//      -> q=1,2,3,0,1. tc high only in the cycle after 3->0. qb=~q throughout.
//   2. q=0, up=0, en=1 -> q=3 with tc=1 for one cycle, then 2,1,0.
//      t_vec=2'b11 on each 0->3 cycle.
//   3. W=3, MAX=5: load=1, load_val=7 -> q=5. Next up count -> q=0, tc=1.
//      cout=1 in the cycle where q=5 & en.
//   4. Reset priority: clear=0 with load=1, load_val=2, en=1 at q=2 -> q=0, tc=0.
//      Counting resumes from 0 the edge after clear returns to 1.
//   5. Hold: en=1, cin=0 for 3 edges at q=2 -> q stays 2, t_vec=0, tc=0.
//      Then cin=1 -> q=3.
//   6. Cascade two W=2 instances (low.cout -> high.cin), count up 16 edges
//      -> {high.q,low.q} runs 0..15 then back to 0. high.tc pulses once.

Source files
------------

// File: rtl/tff_updown_counter.sv
// Up/down modulo counter built from a bank of T flip-flop stages, with a
// cascade carry (cin/cout), clamped parallel load and a terminal-count pulse.
module tff_updown_counter #(
  parameter int unsigned W   = 2,
  parameter int unsigned MAX = (2 ** W) - 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic         cin,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic [W-1:0] qb,
  output logic [W-1:0] t_vec,
  output logic         cout,
  output logic         tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic         cnt_c;
  logic         at_max_c;
  logic         at_zero_c;
  logic         wrap_c;
  logic [W-1:0] clamp_c;
  logic [W-1:0] q_next_c;

  // Toggle generation: pick the next count, then express it as bit flips
  always_comb begin
    cnt_c     = en & cin;
    at_max_c  = (q == MAX_V);
    at_zero_c = (q == '0);
    clamp_c   = (load_val > MAX_V) ? MAX_V : load_val;
    q_next_c  = q;
    wrap_c    = 1'b0;
    if (load) begin
      q_next_c = clamp_c;
    end else if (cnt_c) begin
      if (up) begin
        // q above MAX can only be forced; it falls back to 0 like a wrap
        q_next_c = (q >= MAX_V) ? '0 : q + W'(1);
        wrap_c   = at_max_c;
      end else begin
        q_next_c = at_zero_c ? MAX_V : q - W'(1);
        wrap_c   = at_zero_c;
      end
    end
    t_vec = q ^ q_next_c;
    cout  = cnt_c & (up ? at_max_c : at_zero_c);
  end

  // T flip-flop bank: state only changes by toggling, except for clear
  always_ff @(posedge clk) begin
    if (!clear) begin
      q  <= '0;
      qb <= '1;
      tc <= 1'b0;
    end else begin
      q  <= q ^ t_vec;
      qb <= ~(q ^ t_vec);
      tc <= wrap_c;
    end
  end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Bench for tff_updown_counter: W=2/MAX=3, W=3/MAX=5, W=1/MAX=0 and a
// two-stage W=2 cascade, all compared against an arithmetic modulo model.
module tb_tff_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, en, cin, up, load;
  logic [2:0] load_val;

  logic [1:0] a_q, a_qb, a_t;
  logic       a_cout, a_tc;
  logic [2:0] b_q, b_qb, b_t;
  logic       b_cout, b_tc;
  logic [0:0] z_q, z_qb, z_t;
  logic       z_cout, z_tc;
  logic [1:0] l_q, l_qb, l_t, h_q, h_qb, h_t;
  logic       l_cout, l_tc, h_cout, h_tc;

  tff_updown_counter #(.W(2), .MAX(3)) dut_a (
    .clk(clk), .clear(clear), .en(en), .cin(cin), .up(up), .load(load),
    .load_val(load_val[1:0]), .q(a_q), .qb(a_qb), .t_vec(a_t),
    .cout(a_cout), .tc(a_tc));

  tff_updown_counter #(.W(3), .MAX(5)) dut_b (
    .clk(clk), .clear(clear), .en(en), .cin(cin), .up(up), .load(load),
    .load_val(load_val), .q(b_q), .qb(b_qb), .t_vec(b_t),
    .cout(b_cout), .tc(b_tc));

  tff_updown_counter #(.W(1), .MAX(0)) dut_z (
    .clk(clk), .clear(clear), .en(en), .cin(cin), .up(up), .load(load),
    .load_val(load_val[0:0]), .q(z_q), .qb(z_qb), .t_vec(z_t),
    .cout(z_cout), .tc(z_tc));

  tff_updown_counter #(.W(2)) dut_lo (
    .clk(clk), .clear(clear), .en(en), .cin(cin), .up(up), .load(1'b0),
    .load_val(2'b00), .q(l_q), .qb(l_qb), .t_vec(l_t),
    .cout(l_cout), .tc(l_tc));

  tff_updown_counter #(.W(2)) dut_hi (
    .clk(clk), .clear(clear), .en(en), .cin(l_cout), .up(up), .load(1'b0),
    .load_val(2'b00), .q(h_q), .qb(h_qb), .t_vec(h_t),
    .cout(h_cout), .tc(h_tc));

  int errors = 0;
  int checks = 0;
  int ma, mb, mz, mc;
  bit ta, tb_m, tz, tl, th;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: counting is plain modulo (mx+1) arithmetic
  function automatic int nxt(int qv, int mx, bit cl, bit ld, int lv, bit e, bit c, bit u);
    if (!cl) return 0;
    if (ld) return (lv > mx) ? mx : lv;
    if (e && c) return u ? (qv + 1) % (mx + 1) : (qv + mx) % (mx + 1);
    return qv;
  endfunction

  function automatic bit wraps(int qv, int mx, bit cl, bit ld, bit e, bit c, bit u);
    return cl && !ld && e && c && (u ? (qv == mx) : (qv == 0));
  endfunction

  function automatic int casc_nxt(int cv);
    if (!clear) return 0;
    if (en && cin) return up ? (cv + 1) % 16 : (cv + 15) % 16;
    return cv;
  endfunction

  task automatic drive(input bit cl, input bit e, input bit c, input bit u,
                       input bit ld, input logic [2:0] lv);
    clear = cl; en = e; cin = c; up = u; load = ld; load_val = lv;
  endtask

  // One clock: check combinational outputs, advance the model, check registers
  task automatic cycle();
    int na, nb, nz, nc;
    bit lo_carry;
    #1;
    na = nxt(ma, 3, clear, load, int'(load_val[1:0]), en, cin, up);
    nb = nxt(mb, 5, clear, load, int'(load_val), en, cin, up);
    nz = nxt(mz, 0, clear, load, int'(load_val[0]), en, cin, up);
    nc = casc_nxt(mc);
    lo_carry = en && cin && (up ? (mc % 4 == 3) : (mc % 4 == 0));
    if (clear) begin
      chk("a_tvec", 32'(a_t), ma ^ na);
      chk("b_tvec", 32'(b_t), mb ^ nb);
      chk("z_tvec", 32'(z_t), mz ^ nz);
      chk("lo_tvec", 32'(l_t), (mc % 4) ^ (nc % 4));
      chk("hi_tvec", 32'(h_t), (mc / 4) ^ (nc / 4));
    end
    chk("a_cout", 32'(a_cout), 32'(en && cin && (up ? ma == 3 : ma == 0)));
    chk("b_cout", 32'(b_cout), 32'(en && cin && (up ? mb == 5 : mb == 0)));
    chk("z_cout", 32'(z_cout), 32'(en && cin));
    chk("lo_cout", 32'(l_cout), 32'(lo_carry));
    chk("hi_cout", 32'(h_cout), 32'(en && lo_carry && (up ? mc / 4 == 3 : mc / 4 == 0)));
    ta   = wraps(ma, 3, clear, load, en, cin, up);
    tb_m = wraps(mb, 5, clear, load, en, cin, up);
    tz   = wraps(mz, 0, clear, load, en, cin, up);
    tl   = clear && lo_carry;
    th   = clear && en && cin && (up ? mc == 15 : mc == 0);
    ma = na; mb = nb; mz = nz; mc = nc;
    @(posedge clk);
    #1;
    chk("a_q", 32'(a_q), ma);   chk("a_qb", 32'(a_qb), 3 - ma);  chk("a_tc", 32'(a_tc), 32'(ta));
    chk("b_q", 32'(b_q), mb);   chk("b_qb", 32'(b_qb), 7 - mb);  chk("b_tc", 32'(b_tc), 32'(tb_m));
    chk("z_q", 32'(z_q), mz);   chk("z_qb", 32'(z_qb), 1 - mz);  chk("z_tc", 32'(z_tc), 32'(tz));
    chk("casc_q", 32'({h_q, l_q}), mc);
    chk("lo_tc", 32'(l_tc), 32'(tl));
    chk("hi_tc", 32'(h_tc), 32'(th));
  endtask

  initial begin
    int pulses;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    ma = 0; mb = 0; mz = 0; mc = 0;
    chk("rst_a_q", 32'(a_q), 0);   chk("rst_a_qb", 32'(a_qb), 3);
    chk("rst_a_tc", 32'(a_tc), 0); chk("rst_b_qb", 32'(b_qb), 7);
    chk("rst_casc", 32'({h_q, l_q}), 0);

    // Up count wraps 3 -> 0
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    repeat (5) cycle();
    chk("t1_q", 32'(a_q), 1);

    // Down count wraps 0 -> 3
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    cycle();
    chk("t2_q0", 32'(a_q), 0);
    cycle();
    chk("t2_q3", 32'(a_q), 3);
    chk("t2_tc", 32'(a_tc), 1);
    repeat (3) cycle();
    chk("t2_end", 32'(a_q), 0);

    // Clamped load then up wrap on W=3, MAX=5
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
    cycle();
    chk("t3_load", 32'(b_q), 5);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    cycle();
    chk("t3_wrap", 32'(b_q), 0);
    chk("t3_tc", 32'(b_tc), 1);

    // Clear beats load and count
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
    cycle();
    chk("t4_q", 32'(a_q), 0);
    chk("t4_tc", 32'(a_tc), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    cycle();
    chk("t4_resume", 32'(a_q), 1);

    // Hold with cin low
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    repeat (3) cycle();
    chk("t5_hold", 32'(a_q), 2);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    cycle();
    chk("t5_go", 32'(a_q), 3);

    // Cascade 0..15 and back to 0
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("t6_seq", 32'({h_q, l_q}), (i + 1) % 16);
      if (h_tc === 1'b1) pulses++;
    end
    chk("t6_pulses", 32'(pulses), 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 16) != 0, ($urandom % 4) != 0, ($urandom % 8) != 0,
            1'($urandom % 2), ($urandom % 8) == 0, 3'($urandom % 8));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
